// File: rtl/decode_prefix_fsm.sv
// decode_prefix_fsm: byte-serial instruction front end.
// Strips legacy prefixes (recorded as flags) and the first 0x0F escape.
// Packs the remaining body bytes into a 72-bit window. The finished
// instruction is held under a valid/ready handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        byte input handshake; in_byte, in_last
//   out_valid/out_ready      result handshake
//   unescaped_instr          body bytes, byte k at [8k+7:8k]
//   escaped, prefix_*        escape/prefix flags; prefix_seg 7 = none
//   body_len, instr_len, err lengths and error code
// Optional feature: define DECODE_PREFIX_REP_EN to treat 0xF2/0xF3 as prefixes.
module decode_prefix_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] unescaped_instr,
  output logic        escaped,
  output logic        prefix_operand_16bit,
  output logic        prefix_address_16bit,
  output logic        prefix_lock,
  output logic [2:0]  prefix_seg,
  output logic        prefix_rep,
  output logic        prefix_repne,
  output logic [3:0]  body_len,
  output logic [3:0]  instr_len,
  output logic [1:0]  err
);

  localparam int unsigned WIN_BYTES  = 9;
  localparam int unsigned WIN_W      = 8 * WIN_BYTES;
  localparam int unsigned MAX_PREFIX = 4;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_PREFIX = 2'd1;
  localparam logic [1:0] ERR_BODY   = 2'd2;
  localparam logic [1:0] ERR_NO_OPC = 2'd3;
  localparam logic [2:0] SEG_NONE   = 3'd7;

  typedef enum logic [1:0] {S_PREFIX, S_BODY, S_DRAIN, S_OUT} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               esc_q, esc_d;
  logic               op16_q, op16_d;
  logic               ad16_q, ad16_d;
  logic               lock_q, lock_d;
  logic [2:0]         seg_q, seg_d;
  logic               rep_q, rep_d;
  logic               repne_q, repne_d;
  logic [3:0]         body_len_q, body_len_d;
  logic [3:0]         instr_len_q, instr_len_d;
  logic [1:0]         err_q, err_d;
  logic [2:0]         pfx_cnt_q, pfx_cnt_d;

  logic               accept;
  logic               pfx_hit;
  logic [2:0]         seg_code;

  assign accept = in_valid & in_ready_q;

  // Classify the incoming byte as a legacy prefix (and which segment, if any).
  always_comb begin
    pfx_hit  = 1'b0;
    seg_code = SEG_NONE;
    case (in_byte)
      8'h26: begin pfx_hit = 1'b1; seg_code = 3'd0; end
      8'h2E: begin pfx_hit = 1'b1; seg_code = 3'd1; end
      8'h36: begin pfx_hit = 1'b1; seg_code = 3'd2; end
      8'h3E: begin pfx_hit = 1'b1; seg_code = 3'd3; end
      8'h64: begin pfx_hit = 1'b1; seg_code = 3'd4; end
      8'h65: begin pfx_hit = 1'b1; seg_code = 3'd5; end
      8'h66, 8'h67, 8'hF0: pfx_hit = 1'b1;
`ifdef DECODE_PREFIX_REP_EN
      8'hF2, 8'hF3: pfx_hit = 1'b1;
`endif
      default: ;
    endcase
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    esc_d       = esc_q;
    op16_d      = op16_q;
    ad16_d      = ad16_q;
    lock_d      = lock_q;
    seg_d       = seg_q;
    rep_d       = rep_q;
    repne_d     = repne_q;
    body_len_d  = body_len_q;
    instr_len_d = instr_len_q;
    err_d       = err_q;
    pfx_cnt_d   = pfx_cnt_q;

    if (accept && instr_len_q != 4'd15) instr_len_d = instr_len_q + 4'd1;

    case (state_q)
      S_PREFIX: begin
        if (accept) begin
          if (pfx_hit) begin
            if (in_byte == 8'h66) op16_d = 1'b1;
            if (in_byte == 8'h67) ad16_d = 1'b1;
            if (in_byte == 8'hF0) lock_d = 1'b1;
            if (in_byte == 8'hF3) rep_d = 1'b1;
            if (in_byte == 8'hF2) repne_d = 1'b1;
            if (seg_code != SEG_NONE) seg_d = seg_code;
            pfx_cnt_d = pfx_cnt_q + 3'd1;
            // Prefix-overflow outranks "no opcode" when both occur on one byte.
            if (pfx_cnt_q == 3'(MAX_PREFIX)) begin
              err_d   = ERR_PREFIX;
              state_d = in_last ? S_OUT : S_DRAIN;
            end else if (in_last) begin
              err_d   = ERR_NO_OPC;
              state_d = S_OUT;
            end
          end else if (in_byte == 8'h0F) begin
            esc_d = 1'b1;
            if (in_last) begin
              err_d   = ERR_NO_OPC;
              state_d = S_OUT;
            end else begin
              state_d = S_BODY;
            end
          end else begin
            win_d[7:0] = in_byte;
            body_len_d = 4'd1;
            state_d    = in_last ? S_OUT : S_BODY;
          end
        end
      end
      S_BODY: begin
        if (accept) begin
          if (body_len_q == 4'(WIN_BYTES)) begin
            // Overflow: window and body length read as zero on error.
            err_d      = ERR_BODY;
            win_d      = '0;
            body_len_d = 4'd0;
            state_d    = in_last ? S_OUT : S_DRAIN;
          end else begin
            for (int k = 0; k < WIN_BYTES; k++) begin
              if (body_len_q == 4'(k)) win_d[8*k +: 8] = in_byte;
            end
            body_len_d = body_len_q + 4'd1;
            if (in_last) state_d = S_OUT;
          end
        end
      end
      S_DRAIN: begin
        if (accept && in_last) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_PREFIX;
          win_d       = '0;
          esc_d       = 1'b0;
          op16_d      = 1'b0;
          ad16_d      = 1'b0;
          lock_d      = 1'b0;
          seg_d       = SEG_NONE;
          rep_d       = 1'b0;
          repne_d     = 1'b0;
          body_len_d  = 4'd0;
          instr_len_d = 4'd0;
          err_d       = ERR_NONE;
          pfx_cnt_d   = 3'd0;
        end
      end
      default: state_d = S_PREFIX;
    endcase

    in_ready_d  = (state_d != S_OUT);
    out_valid_d = (state_d == S_OUT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PREFIX;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      win_q       <= '0;
      esc_q       <= 1'b0;
      op16_q      <= 1'b0;
      ad16_q      <= 1'b0;
      lock_q      <= 1'b0;
      seg_q       <= SEG_NONE;
      rep_q       <= 1'b0;
      repne_q     <= 1'b0;
      body_len_q  <= 4'd0;
      instr_len_q <= 4'd0;
      err_q       <= ERR_NONE;
      pfx_cnt_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
      esc_q       <= esc_d;
      op16_q      <= op16_d;
      ad16_q      <= ad16_d;
      lock_q      <= lock_d;
      seg_q       <= seg_d;
      rep_q       <= rep_d;
      repne_q     <= repne_d;
      body_len_q  <= body_len_d;
      instr_len_q <= instr_len_d;
      err_q       <= err_d;
      pfx_cnt_q   <= pfx_cnt_d;
    end
  end

  assign in_ready             = in_ready_q;
  assign out_valid            = out_valid_q;
  assign unescaped_instr      = win_q;
  assign escaped              = esc_q;
  assign prefix_operand_16bit = op16_q;
  assign prefix_address_16bit = ad16_q;
  assign prefix_lock          = lock_q;
  assign prefix_seg           = seg_q;
  assign body_len             = body_len_q;
  assign instr_len            = instr_len_q;
  assign err                  = err_q;
`ifdef DECODE_PREFIX_REP_EN
  assign prefix_rep           = rep_q;
  assign prefix_repne         = repne_q;
`else
  // Without the rep feature no F2/F3 prefix is ever decoded, so these stay 0.
  assign prefix_rep           = 1'b0;
  assign prefix_repne         = 1'b0;
`endif

endmodule
